panel_line_reader: RTL and testbench

- Ctrl-bus initiator that reads one 32-pixel line back out of the LED panel framebuffer and packs it into a 32-bit bitmask.
- It is the read-side counterpart of the line writer. Bit i of the result is column i of the requested line.
- Sits beside the panel controller on the shared ctrl_* bus. Used for self-check and readback of displayed patterns.

---
 rtl/panel_line_reader.sv | 131 +++++++++++++
 tb/tb_panel_line_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_line_reader.sv
// panel_line_reader: reads one 32-pixel framebuffer line over the ctrl_* bus and packs it into a bitmask.
// Define LINE_READER_MATCH_EN to set a bit when the pixel equals match_color instead of when it is non-zero.
module panel_line_reader #(
    parameter int TIMEOUT = 255,
    parameter int PIXEL_W = 24
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rd_start,
    input  logic [4:0]         rd_line,
    input  logic [PIXEL_W-1:0] match_color,
    output logic               busy,
    output logic               rd_valid,
    output logic [31:0]        rd_value,
    output logic               rd_error,
    output logic [3:0]         ctrl_wr,
    output logic               ctrl_rd,
    output logic [15:0]        ctrl_addr,
    input  logic [31:0]        ctrl_rdat,
    input  logic               ctrl_done
);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    state_t        state, state_n;
    logic [4:0]    line_q, line_n, col, col_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [31:0]   shadow, shadow_n, value_n;
    logic [15:0]   addr_n;
    logic          rd_n, busy_n, valid_n, error_n, hit;
    logic          unused_ok;

    assign ctrl_wr   = 4'b0000;
    assign cnt_inc   = cnt + 1'b1;
    assign unused_ok = ^{match_color, ctrl_rdat};

`ifdef LINE_READER_MATCH_EN
    logic [PIXEL_W-1:0] color_q;
    always_ff @(posedge clk)
        if (!resetn)
            color_q <= '0;
        else if (state == IDLE && rd_start && !rd_valid)
            color_q <= match_color;
    assign hit = ctrl_rdat[PIXEL_W-1:0] == color_q;
`else
    assign hit = |ctrl_rdat[PIXEL_W-1:0];
`endif

    always_comb begin
        state_n  = state;
        line_n   = line_q;
        col_n    = col;
        cnt_n    = cnt;
        shadow_n = shadow;
        value_n  = rd_value;
        addr_n   = ctrl_addr;
        rd_n     = ctrl_rd;
        busy_n   = busy;
        valid_n  = 1'b0;
        error_n  = 1'b0;
        case (state)
            IDLE:
                // a start landing on the rd_valid cycle is dropped
                if (rd_start && !rd_valid) begin
                    line_n  = rd_line;
                    col_n   = 5'd0;
                    addr_n  = {4'b0, 5'd0, ~rd_line, 2'b00};
                    rd_n    = 1'b1;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = REQ;
                end
            REQ:
                if (ctrl_done) begin
                    rd_n        = 1'b0;
                    shadow_n[col] = hit;
                    col_n       = col == 5'd31 ? col : col + 5'd1;
                    state_n     = col == 5'd31 ? DONE : GAP;
                end else if (TIMEOUT != 0 && cnt_inc == CW'(TIMEOUT)) begin
                    rd_n    = 1'b0;
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            GAP: begin
                // (c*32 + 31 - L) * 4: 31-L is the 5-bit complement of L
                addr_n  = {4'b0, col, ~line_q, 2'b00};
                rd_n    = 1'b1;
                cnt_n   = '0;
                state_n = REQ;
            end
            DONE: begin
                value_n = shadow;
                valid_n = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (!resetn) begin
            state     <= IDLE;
            line_q    <= '0;
            col       <= '0;
            cnt       <= '0;
            shadow    <= '0;
            rd_value  <= '0;
            ctrl_addr <= '0;
            ctrl_rd   <= 1'b0;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_error  <= 1'b0;
        end else begin
            state     <= state_n;
            line_q    <= line_n;
            col       <= col_n;
            cnt       <= cnt_n;
            shadow    <= shadow_n;
            rd_value  <= value_n;
            ctrl_addr <= addr_n;
            ctrl_rd   <= rd_n;
            busy      <= busy_n;
            rd_valid  <= valid_n;
            rd_error  <= error_n;
        end
endmodule

// File: tb/tb_panel_line_reader.sv
// tb_panel_line_reader: random and directed line reads against a framebuffer model,
// with a scoreboard of expected completions and a queue of expected bus addresses.
module tb_panel_line_reader;
    localparam int TIMEOUT = 255;
    localparam int PIXEL_W = 24;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               rd_start = 1'b0;
    logic [4:0]         rd_line = '0;
    logic [PIXEL_W-1:0] match_color = '0;
    logic               busy, rd_valid, rd_error, ctrl_rd;
    logic [31:0]        rd_value;
    logic [3:0]         ctrl_wr;
    logic [15:0]        ctrl_addr;
    logic [31:0]        ctrl_rdat = '0;
    logic               ctrl_done = 1'b0;

    always #5 clk = ~clk;

    panel_line_reader #(.TIMEOUT(TIMEOUT), .PIXEL_W(PIXEL_W)) dut (
        .clk(clk), .resetn(resetn), .rd_start(rd_start), .rd_line(rd_line),
        .match_color(match_color), .busy(busy), .rd_valid(rd_valid), .rd_value(rd_value),
        .rd_error(rd_error), .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr),
        .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] val;
    } exp_t;

    exp_t               sb[$];
    logic [15:0]        addr_q[$];
    logic [PIXEL_W-1:0] fb[32][32];
    logic [31:0]        last_val = '0;
    exp_t               mon_e;
    int total = 0, bad = 0;
    int dly = 1, rises = 0, low_cnt = 0, wait_cnt = 0, rd_high = 0, r_idx = 0;
    bit mute = 1'b0, stray = 1'b0, answered = 1'b0, prev_rd = 1'b0, prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // framebuffer responder: answers each request dly cycles after ctrl_rd rises
    always @(posedge clk) begin
        #1;
        ctrl_done = 1'b0;
        if (ctrl_rd) rd_high++;
        if (ctrl_rd && !prev_rd) begin
            if (rises > 0) chk("gap_low_cycles", low_cnt, 1);
            if (addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_request: addr %0h with no request expected", ctrl_addr);
            end else chk("addr", ctrl_addr, addr_q.pop_front());
            rises++;
            low_cnt = 0;
        end
        if (!ctrl_rd) begin
            low_cnt++;
            answered = 1'b0;
            wait_cnt = 0;
        end else if (!answered && !mute) begin
            wait_cnt++;
            if (wait_cnt == dly) begin
                r_idx = ctrl_addr / 4;
                ctrl_rdat = {8'($urandom), fb[31 - r_idx % 32][r_idx / 32]};
                ctrl_done = 1'b1;
                answered = 1'b1;
            end
        end
        if (stray && !ctrl_rd) begin
            ctrl_rdat = $urandom;
            ctrl_done = 1'b1;
            stray = 1'b0;
        end
        prev_rd = ctrl_rd;
    end

    always @(negedge clk) begin
        if (rd_valid) chk("valid_width", prev_valid, 0);
        if (rd_valid || rd_error) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: valid=%0b err=%0b none expected", rd_valid, rd_error);
            end else begin
                mon_e = sb.pop_front();
                chk("kind_err", rd_error, mon_e.err);
                chk("kind_valid", rd_valid, !mon_e.err);
                chk("rd_value", rd_value, mon_e.val);
                chk("ctrl_wr", ctrl_wr, 0);
            end
        end
        prev_valid = rd_valid;
    end

    task automatic do_read(input int l, input int d, input bit m, input bit poke);
        logic [31:0] exp_v;
        exp_t e;
        int n;
        dly = d;
        mute = m;
        rises = 0;
        for (int c = 0; c < 32; c++) begin
`ifdef LINE_READER_MATCH_EN
            exp_v[c] = fb[l][c] == match_color;
`else
            exp_v[c] = fb[l][c] != 0;
`endif
            if (!m || c == 0) addr_q.push_back(16'((c * 32 + 31 - l) * 4));
        end
        e.err = m;
        e.val = m ? last_val : exp_v;
        sb.push_back(e);
        if (!m) last_val = exp_v;
        @(negedge clk);
        rd_start = 1'b1;
        rd_line = 5'(l);
        rd_high = 0;
        @(negedge clk);
        rd_start = 1'b0;
        rd_line = 5'($urandom);
        match_color = PIXEL_W'($urandom);
        n = 1;
        while (busy && n < 20000) begin
            rd_start = poke && n == 20;
            if (poke && n == 20) rd_line = 5'd7;
            @(negedge clk);
            n++;
        end
        rd_start = 1'b0;
        chk("latency", n, m ? TIMEOUT + 1 : 32 * d + 33);
        chk("rd_high_cycles", rd_high, m ? TIMEOUT : 32 * d);
        if (!m) begin
            rd_start = 1'b1;
            rd_line = 5'(l + 1);
            @(negedge clk);
            rd_start = 1'b0;
            chk("start_on_valid_ignored", busy, 0);
        end
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("addr_drained", addr_q.size(), 0);
    endtask

    task automatic fill_random(input int l);
        for (int c = 0; c < 32; c++) begin
            case ($urandom_range(0, 2))
                0: fb[l][c] = '0;
                1: fb[l][c] = match_color;
                default: fb[l][c] = PIXEL_W'($urandom);
            endcase
        end
    endtask

    initial begin
        for (int l = 0; l < 32; l++)
            for (int c = 0; c < 32; c++) fb[l][c] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ctrl_rd", ctrl_rd, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_error", rd_error, 0);
        chk("rst_addr", ctrl_addr, 0);
        chk("rst_value", rd_value, 0);
        chk("rst_wr", ctrl_wr, 0);
        resetn = 1'b1;
        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_done_idle", busy, 0);

        match_color = 24'hFF0000;
        for (int c = 0; c < 32; c++) fb[3][c] = c % 2 == 0 ? 24'hFF0000 : 24'h0;
        do_read(3, 1, 0, 0);

        match_color = 24'h123456;
        fb[0][0] = 24'h123456;
        fb[0][31] = 24'h123456;
        do_read(0, 5, 0, 0);

        match_color = 24'h00FF00;
        fill_random(12);
        do_read(12, 1, 1, 0);
        match_color = 24'h00FF00;
        do_read(12, 1, 0, 0);

        match_color = 24'hA5A5A5;
        fill_random(20);
        do_read(20, 2, 0, 1);

        match_color = 24'h00FF00;
        for (int c = 0; c < 32; c++) fb[6][c] = c % 2 == 0 ? 24'h00FF00 : 24'hFF0000;
        do_read(6, 1, 0, 0);

        match_color = 24'h0000FF;
        fill_random(1);
        do_read(1, TIMEOUT, 0, 0);

        for (int i = 0; i < 6; i++) begin
            automatic int l = $urandom_range(0, 31);
            match_color = PIXEL_W'($urandom);
            fill_random(l);
            do_read(l, $urandom_range(1, 4), 0, 0);
        end

        fill_random(9);
        dly = 2;
        mute = 1'b0;
        rises = 0;
        for (int c = 0; c <= 10; c++) addr_q.push_back(16'((c * 32 + 31 - 9) * 4));
        @(negedge clk);
        rd_start = 1'b1;
        rd_line = 5'd9;
        @(negedge clk);
        rd_start = 1'b0;
        for (int n = 0; n < 2000 && !(rises == 11 && ctrl_rd); n++) @(negedge clk);
        chk("reached_col10", rises, 11);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl_rd", ctrl_rd, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_error", rd_error, 0);
        chk("midrst_value", rd_value, 0);
        resetn = 1'b1;
        last_val = '0;
        addr_q.delete();
        repeat (80) @(negedge clk);

        match_color = 24'h00FF00;
        fill_random(30);
        do_read(30, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
